aes_tcdm_banked_mem: RTL and testbench

AES_TCDM_BANKED_MEM -- requirements
Module: aes_tcdm_banked_mem

---
 rtl/aes_tcdm_banked_mem.sv | 152 +++++++++++++++
 tb/tb_aes_tcdm_banked_mem.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/aes_tcdm_banked_mem.sv
// Word-interleaved multi-bank TCDM with per-bank round-robin arbitration.
// One-cycle response latency; reads return the pre-write bank contents.
module aes_tcdm_banked_mem #(
  parameter int          MP         = 4,
  parameter int          N_BANKS    = 4,
  parameter int          BANK_WORDS = 256,
  parameter logic [31:0] BASE_ADDR  = 32'h1000_0000
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [MP-1:0]        tcdm_req,
  output logic [MP-1:0]        tcdm_gnt,
  input  logic [MP-1:0][31:0]  tcdm_add,
  input  logic [MP-1:0]        tcdm_wen,
  input  logic [MP-1:0][3:0]   tcdm_be,
  input  logic [MP-1:0][31:0]  tcdm_data,
  output logic [MP-1:0][31:0]  tcdm_r_data,
  output logic [MP-1:0]        tcdm_r_valid,
  output logic [31:0]          conflict_cnt_o
);

  localparam int BW = $clog2(N_BANKS);
  localparam int RW = $clog2(BANK_WORDS);
  localparam int PW = (MP > 1) ? $clog2(MP) : 1;
  localparam logic [32:0] TOTAL =
    33'(N_BANKS) * 33'(BANK_WORDS) * 33'd4;

  logic [31:0]        w_off  [MP];
  logic [MP-1:0]      w_oor;
  logic [BW-1:0]      w_bank [MP];
  logic [RW-1:0]      w_row  [MP];

  logic [PW-1:0]      r_ptr  [N_BANKS];
  logic [N_BANKS-1:0] w_bvld;
  logic [PW-1:0]      w_bwin [N_BANKS];
  logic [31:0]        w_bq   [N_BANKS];

  logic [MP-1:0]      r_vld;
  logic [MP-1:0]      r_rd;
  logic [BW-1:0]      r_rbank [MP];
  logic [31:0]        r_cnt;

  always_comb begin
    for (int p = 0; p < MP; p++) begin
      w_off[p]  = tcdm_add[p] - BASE_ADDR;
      w_oor[p]  = (tcdm_add[p] < BASE_ADDR) ||
                  ({1'b0, w_off[p]} >= TOTAL);
      w_bank[p] = w_off[p][2 +: BW];
      w_row[p]  = w_off[p][2+BW +: RW];
    end
  end

  // Search from the bank pointer upward, wrapping at MP.
  always_comb begin
    logic [PW:0]   w_s;
    logic [PW-1:0] w_i;
    w_bvld = '0;
    for (int b = 0; b < N_BANKS; b++) begin
      w_bwin[b] = '0;
      for (int k = 0; k < MP; k++) begin
        w_s = {1'b0, r_ptr[b]} + (PW+1)'(k);
        if (w_s >= (PW+1)'(MP))
          w_s = w_s - (PW+1)'(MP);
        w_i = w_s[PW-1:0];
        if (!w_bvld[b] && tcdm_req[w_i] && !w_oor[w_i] &&
            w_bank[w_i] == BW'(b)) begin
          w_bvld[b] = 1'b1;
          w_bwin[b] = w_i;
        end
      end
    end
    if (rst_i)
      w_bvld = '0;
  end

  always_comb begin
    for (int p = 0; p < MP; p++) begin
      tcdm_gnt[p] = tcdm_req[p] && !rst_i &&
        (w_oor[p] ||
         (w_bvld[w_bank[p]] && w_bwin[w_bank[p]] == PW'(p)));
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int b = 0; b < N_BANKS; b++)
        r_ptr[b] <= '0;
    end else begin
      for (int b = 0; b < N_BANKS; b++)
        if (w_bvld[b])
          r_ptr[b] <= (w_bwin[b] == PW'(MP-1)) ? '0
                                               : w_bwin[b] + 1'b1;
    end
  end

  for (genvar b = 0; b < N_BANKS; b++) begin : g_bank
    logic [31:0]   r_mem [BANK_WORDS];
    logic [31:0]   r_q;
    logic [RW-1:0] w_brow;
    logic          w_bwe;
    logic [3:0]    w_bbe;
    logic [31:0]   w_bwd;

    assign w_brow = w_row[w_bwin[b]];
    assign w_bwe  = w_bvld[b] & ~tcdm_wen[w_bwin[b]];
    assign w_bbe  = tcdm_be[w_bwin[b]];
    assign w_bwd  = tcdm_data[w_bwin[b]];

    always_ff @(posedge clk_i) begin
      if (w_bvld[b]) begin
        r_q <= r_mem[w_brow];
        if (w_bwe)
          for (int j = 0; j < 4; j++)
            if (w_bbe[j])
              r_mem[w_brow][8*j +: 8] <= w_bwd[8*j +: 8];
      end
    end

    assign w_bq[b] = r_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_vld <= '0;
      r_rd  <= '0;
    end else begin
      r_vld <= tcdm_gnt;
      r_rd  <= tcdm_gnt & tcdm_wen & ~w_oor;
    end
    for (int p = 0; p < MP; p++)
      r_rbank[p] <= w_bank[p];
  end

  // A response owed across a reset assertion is dropped.
  always_comb begin
    for (int p = 0; p < MP; p++) begin
      tcdm_r_valid[p] = r_vld[p] & ~rst_i;
      tcdm_r_data[p]  = (r_rd[p] && !rst_i) ? w_bq[r_rbank[p]]
                                             : 32'h0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)
      r_cnt <= '0;
    else if ((|(tcdm_req & ~tcdm_gnt)) && r_cnt != 32'hFFFF_FFFF)
      r_cnt <= r_cnt + 32'd1;
  end

  assign conflict_cnt_o = r_cnt;

endmodule

// File: tb/tb_aes_tcdm_banked_mem.sv
// Bench for aes_tcdm_banked_mem: cycle table with expected grants,
// reference memory model and a response scoreboard.
module tb_aes_tcdm_banked_mem;

  localparam logic [31:0] B = 32'h1000_0000;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [3:0]        req = '0;
  logic [3:0]        gnt;
  logic [3:0][31:0]  add = '0;
  logic [3:0]        wen = '1;
  logic [3:0][3:0]   be  = '0;
  logic [3:0][31:0]  dat = '0;
  logic [3:0][31:0]  rdat;
  logic [3:0]        rvld;
  logic [31:0]       cnt;

  aes_tcdm_banked_mem dut (
    .clk_i(clk), .rst_i(rst),
    .tcdm_req(req), .tcdm_gnt(gnt), .tcdm_add(add),
    .tcdm_wen(wen), .tcdm_be(be), .tcdm_data(dat),
    .tcdm_r_data(rdat), .tcdm_r_valid(rvld),
    .conflict_cnt_o(cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic             rst;
    logic [3:0]       req;
    logic [3:0]       wen;
    logic [3:0][31:0] add;
    logic [3:0][3:0]  be;
    logic [3:0][31:0] dat;
    logic [3:0]       gnt;
  } vec_t;

  typedef struct {
    int          port;
    int          due;
    logic [31:0] data;
  } exp_t;

  vec_t        tbl[$];
  exp_t        sb[$];
  logic [31:0] mdl [int];
  int          ncmp = 0;
  int          nfail = 0;
  logic [31:0] cnt_m = 0;

  function automatic vec_t mk(logic r, logic [3:0] rq,
                              logic [3:0] w, logic [3:0] g);
    vec_t v;
    v.rst = r; v.req = rq; v.wen = w; v.gnt = g;
    for (int p = 0; p < 4; p++) begin
      v.add[p] = B; v.be[p] = 4'hF; v.dat[p] = 32'h0;
    end
    return v;
  endfunction

  function automatic bit inr(logic [31:0] a);
    return (a >= B) && ((a - B) < 32'h1000);
  endfunction

  task automatic chk(string nm, int st, logic [31:0] act,
                     logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s step %0d: got %h want %h", nm, st, act, exp);
    end
  endtask

  initial begin
    vec_t        v;
    exp_t        e;
    logic [3:0]  ev;
    logic [31:0] ed [4];
    logic [31:0] w;
    int          k;
    bit          got;

    v = mk(0, 4'b0000, 4'b1111, 4'b0000); tbl.push_back(v);
    v = mk(0, 4'b0001, 4'b1110, 4'b0001);
    v.dat[0] = 32'hCAFE_BABE; tbl.push_back(v);
    v = mk(0, 4'b0001, 4'b1111, 4'b0001); tbl.push_back(v);
    v = mk(0, 4'b0010, 4'b1101, 4'b0010);
    v.add[1] = B + 32'h10; v.dat[1] = 32'hAABB_CCDD; tbl.push_back(v);
    v.dat[1] = 32'h1122_3344; v.be[1] = 4'b0101; tbl.push_back(v);
    v = mk(0, 4'b0010, 4'b1111, 4'b0010);
    v.add[1] = B + 32'h10; tbl.push_back(v);
    v = mk(0, 4'b1111, 4'b0000, 4'b1111);
    v.add[0] = B + 32'h4;  v.dat[0] = 32'h0101_0001;
    v.add[1] = B + 32'h8;  v.dat[1] = 32'h0202_0002;
    v.add[2] = B + 32'hC;  v.dat[2] = 32'h0303_0003;
    v.add[3] = B + 32'h20; v.dat[3] = 32'h0404_0004;
    tbl.push_back(v);
    v = mk(0, 4'b1111, 4'b1111, 4'b1111);
    v.add[1] = B + 32'h4; v.add[2] = B + 32'h8; v.add[3] = B + 32'hC;
    tbl.push_back(v);
    v = mk(0, 4'b0000, 4'b1111, 4'b0000); tbl.push_back(v);
    v = mk(1, 4'b0001, 4'b1110, 4'b0000);
    v.dat[0] = 32'hDEAD_BEEF; tbl.push_back(v);
    v = mk(0, 4'b1111, 4'b1111, 4'b0001); tbl.push_back(v);
    v = mk(0, 4'b1111, 4'b1111, 4'b0010); tbl.push_back(v);
    v = mk(0, 4'b1111, 4'b1111, 4'b0100); tbl.push_back(v);
    v = mk(0, 4'b1111, 4'b1111, 4'b1000); tbl.push_back(v);
    v = mk(0, 4'b0111, 4'b1110, 4'b0111);
    v.add[0] = B + 32'h1000; v.dat[0] = 32'h1234_5678;
    v.add[1] = B - 32'h4;    v.add[2] = B + 32'h1000;
    tbl.push_back(v);
    v = mk(0, 4'b1000, 4'b1111, 4'b1000); tbl.push_back(v);
    v = mk(0, 4'b0001, 4'b1111, 4'b0001);
    v.add[0] = B + 32'h4; tbl.push_back(v);
    v = mk(1, 4'b0000, 4'b1111, 4'b0000); tbl.push_back(v);
    v = mk(0, 4'b0000, 4'b1111, 4'b0000); tbl.push_back(v);
    v = mk(0, 4'b0100, 4'b1011, 4'b0100);
    v.add[2] = B + 32'h8; v.dat[2] = 32'hFFFF_FFFF; v.be[2] = 4'b0000;
    tbl.push_back(v);
    v = mk(0, 4'b0100, 4'b1111, 4'b0100);
    v.add[2] = B + 32'h8; tbl.push_back(v);
    v = mk(0, 4'b1010, 4'b1111, 4'b0010);
    v.add[1] = B + 32'h4; v.add[3] = B + 32'h4; tbl.push_back(v);
    v = mk(0, 4'b1001, 4'b1111, 4'b1000);
    v.add[0] = B + 32'h4; v.add[3] = B + 32'h4; tbl.push_back(v);
    v = mk(0, 4'b0001, 4'b1111, 4'b0001);
    v.add[0] = B + 32'h4; tbl.push_back(v);
    v = mk(0, 4'b0000, 4'b1111, 4'b0000); tbl.push_back(v);

    repeat (2) @(posedge clk);

    for (int s = 0; s < tbl.size(); s++) begin
      v = tbl[s];
      @(posedge clk); #1;
      rst = v.rst; req = v.req; wen = v.wen;
      add = v.add; be = v.be; dat = v.dat;
      #1;
      ev = '0;
      for (int p = 0; p < 4; p++) ed[p] = 32'h0;
      while (sb.size() > 0 && sb[0].due == s) begin
        e = sb.pop_front();
        if (!v.rst) begin
          ev[e.port] = 1'b1;
          ed[e.port] = e.data;
        end
      end
      chk("gnt", s, {28'h0, gnt}, {28'h0, v.gnt});
      chk("r_valid", s, {28'h0, rvld}, {28'h0, ev});
      for (int p = 0; p < 4; p++)
        chk($sformatf("r_data%0d", p), s, rdat[p], ed[p]);
      chk("conflict_cnt", s, cnt, cnt_m);

      if (v.rst) begin
        cnt_m = 0;
        sb.delete();
      end else begin
        if ((v.req & ~v.gnt) != 4'h0 && cnt_m != 32'hFFFF_FFFF)
          cnt_m = cnt_m + 1;
        for (int p = 0; p < 4; p++) begin
          if (v.gnt[p]) begin
            e.port = p; e.due = s + 1; e.data = 32'h0;
            if (v.wen[p] && inr(v.add[p]))
              e.data = mdl[int'((v.add[p] - B) >> 2)];
            sb.push_back(e);
          end
        end
        for (int p = 0; p < 4; p++) begin
          if (v.gnt[p] && !v.wen[p] && inr(v.add[p])) begin
            k = int'((v.add[p] - B) >> 2);
            w = mdl.exists(k) ? mdl[k] : 32'h0;
            for (int j = 0; j < 4; j++)
              if (v.be[p][j]) w[8*j +: 8] = v.dat[p][8*j +: 8];
            mdl[k] = w;
          end
        end
      end
    end

    @(posedge clk); #1;
    req = 4'b0001; wen = 4'b1111; add[0] = B + 32'h10; be = '1;
    #1;
    chk("hs_gnt", 0, {28'h0, gnt}, 32'h1);
    @(posedge clk); #1;
    req = '0;
    got = 0;
    for (int i = 0; i < 4 && !got; i++) begin
      if (rvld[0]) got = 1;
      else begin @(posedge clk); #1; end
    end
    chk("hs_rvalid", 0, {31'h0, got}, 32'h1);
    chk("hs_rdata", 0, rdat[0], 32'hAA22_CC44);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nfail);
    $finish;
  end

endmodule
